shot_scheduler: RTL

Sequencing controller for the 160x120 projectile shifter grid. Runs the game-state machine, generates the periodic row-shift strobe, and turns player shoot presses into single-cycle, rate-limited load strobes with a latched column. Sits between the switch/player-position inputs and the grid's reset, shift and load controls, replacing free-running control of those pins.

---
 rtl/shot_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/shot_scheduler.sv
// Game-state sequencer for the projectile shifter grid: grid clear, periodic
// row-shift strobe, and rate-limited single-cycle shot load strobes.
module shot_scheduler #(
  parameter int unsigned TICK_DIV     = 3_125_000,
  parameter int unsigned COLS         = 160,
  parameter int unsigned COOLDOWN     = 4,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_game_over,
  input  logic        i_shoot,
  input  logic [7:0]  i_user_x,
  output logic        o_grid_clear,
  output logic        o_shift_en,
  output logic        o_load_en,
  output logic [7:0]  o_load_col,
  output logic [2:0]  o_state,
  output logic [15:0] o_shots_fired
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // CLEAR | grid_clear held, counters reloaded
  // PLAY  | shift strobes running, shots accepted
  // PAUSE | counters frozen, shots ignored
  // OVER  | game ended, waiting for start with game_over low
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LD  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COOL_LD  = CW'(COOLDOWN);
  localparam logic [KW-1:0] CLR_LD   = KW'(CLEAR_CYCLES - 1);
  localparam logic [8:0]    COLS_LIM = 9'(COLS);

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tick;
  logic [CW-1:0]   r_cool;
  logic [KW-1:0]   r_clr_cnt;
  logic            r_pending;
  logic            r_shoot_q;

  logic            w_run;
  logic            w_rise;
  logic            w_tick_zero;
  logic            w_shift_next;
  logic            w_accept;
  logic            w_req;
  logic            w_issue;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_cnt == '0) w_next = S_PLAY;
      S_PLAY: begin
        if (i_game_over)  w_next = S_OVER;
        else if (i_pause) w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (i_game_over)   w_next = S_OVER;
        else if (!i_pause) w_next = S_PLAY;
      end
      S_OVER:  if (i_start && !i_game_over) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  // Play logic advances only in cycles that stay in PLAY, so the cycle that
  // leaves for PAUSE/OVER freezes counters and suppresses strobes and rises.
  assign w_run        = (r_state == S_PLAY) && (w_next == S_PLAY);
  assign w_rise       = i_shoot & ~r_shoot_q;
  assign w_tick_zero  = (r_tick == '0);
  assign w_shift_next = w_run && w_tick_zero;
  assign w_accept     = w_run && w_rise && (r_cool == '0) && !r_pending &&
                        ({1'b0, i_user_x} < COLS_LIM);
  assign w_req        = w_run && (r_pending || w_accept);
  assign w_issue      = w_req && !w_tick_zero;

  assign o_state = r_state;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_cool        <= '0;
      r_clr_cnt     <= '0;
      r_pending     <= 1'b0;
      r_shoot_q     <= 1'b0;
      o_grid_clear  <= 1'b0;
      o_shift_en    <= 1'b0;
      o_load_en     <= 1'b0;
      o_load_col    <= '0;
      o_shots_fired <= '0;
    end else begin
      r_state      <= w_next;
      r_shoot_q    <= i_shoot;
      o_grid_clear <= (w_next == S_CLEAR);
      o_shift_en   <= w_shift_next;
      o_load_en    <= w_issue;

      if (w_next == S_CLEAR && r_state != S_CLEAR) r_clr_cnt <= CLR_LD;
      else if (r_state == S_CLEAR && r_clr_cnt != '0) r_clr_cnt <= r_clr_cnt - KW'(1);

      if (w_accept) o_load_col <= i_user_x;

      if (w_next == S_CLEAR) begin
        r_tick        <= TICK_LD;
        r_cool        <= '0;
        r_pending     <= 1'b0;
        o_shots_fired <= '0;
      end else if (w_run) begin
        r_tick    <= w_tick_zero ? TICK_LD : (r_tick - TW'(1));
        r_pending <= w_req && w_tick_zero;
        if (w_issue) r_cool <= COOL_LD;
        else if (w_shift_next && r_cool != '0) r_cool <= r_cool - CW'(1);
        if (w_issue && o_shots_fired != 16'hFFFF) o_shots_fired <= o_shots_fired + 16'd1;
      end else begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule
